// File: rtl/fifo_read_sequencer_pkg.sv
// Shared definitions for the FIFO read-side sequencer: state encoding and default widths.
package fifo_read_sequencer_pkg;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_LENW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fifo_read_sequencer_skid_buf.sv
// Two-entry order-preserving buffer between the FIFO head and the output stream.
module fifo_read_sequencer_skid_buf
  import fifo_read_sequencer_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] dout,
  output logic [1:0]       cnt
);

  logic [DSIZE-1:0] mem_q [2];
  logic [DSIZE-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_ok, push_ok;

  // Guards keep the count legal even if a caller misbehaves.
  assign pop_ok  = pop & (cnt_q != 2'd0);
  assign push_ok = push & ((cnt_q != 2'd2) | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_read_sequencer.sv
// Read-domain sequencer: pops the async FIFO, buffers two words and emits a framed
// valid/ready byte stream with enable/flush control.
module fifo_read_sequencer
  import fifo_read_sequencer_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int LENW  = DEF_LENW
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             enable,
  input  logic             flush,
  input  logic [LENW-1:0]  frame_len,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [LENW-1:0]  frame_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Stream handshake: a beat transfers on every rclk edge where m_valid & m_ready;
  // m_valid never drops and m_data never changes until that beat is accepted.

  seq_state_e      state_q, state_d;
  logic [LENW-1:0] frame_cnt_q, frame_cnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] eff_len, last_idx;
  logic [1:0]      buf_cnt;
  logic            accept, buf_push, buf_pop;

  fifo_read_sequencer_skid_buf #(.DSIZE(DSIZE)) u_buf (
    .clk   (rclk),
    .rst   (rrst),
    .clear (flush),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (rdata),
    .dout  (m_data),
    .cnt   (buf_cnt)
  );

  assign m_valid = (buf_cnt != 2'd0);
  assign accept  = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  if (enable) state_d = ST_RUN;
        ST_RUN:   if (!enable) state_d = ST_IDLE;
        ST_FLUSH: if (rempty) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // In FLUSH the popped words are dropped; only RUN pops land in the buffer.
  always_comb begin
    rinc = 1'b0;
    case (state_q)
      ST_RUN:   rinc = !rempty & ((buf_cnt != 2'd2) | accept);
      ST_FLUSH: rinc = !rempty;
      default:  rinc = 1'b0;
    endcase
  end

  assign buf_push = rinc & (state_q == ST_RUN) & !flush;
  assign buf_pop  = accept & !flush;

  // Length is live from frame_len until the first beat is taken, then held.
  assign eff_len  = (frame_cnt_q == '0) ? frame_len : len_q;
  assign last_idx = eff_len - LENW'(1);
  assign m_last   = m_valid & (frame_cnt_q == last_idx);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    len_d       = len_q;
    if (flush) begin
      frame_cnt_d = '0;
    end else if (accept) begin
      if (frame_cnt_q == '0) len_d = frame_len;
      frame_cnt_d = m_last ? '0 : frame_cnt_q + LENW'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      len_q       <= len_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign busy      = ((state_q == ST_RUN) & m_valid) | (state_q == ST_FLUSH);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_read_sequencer.sv
// Directed bench for fifo_read_sequencer: FIFO model, expected-beat queue and monitor.
module tb_fifo_read_sequencer;
  import fifo_read_sequencer_pkg::*;

  localparam int DSIZE = 8;
  localparam int LENW  = 8;
  localparam int MEMD  = 1024;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             rempty, rinc;
  logic [DSIZE-1:0] rdata, m_data;
  logic             enable = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic [LENW-1:0]  frame_len = '0, frame_cnt;
  logic             m_valid, m_last, busy;
  logic [1:0]       dbg_state;

  logic [DSIZE-1:0] mem [MEMD];
  int               rd_idx = 0;
  int               wr_idx = 0;
  logic [DSIZE:0]   exp_q [$];
  logic [DSIZE:0]   mon_exp;
  int               n_checks = 0;
  int               n_pass = 0;

  fifo_read_sequencer #(.DSIZE(DSIZE), .LENW(LENW)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .enable    (enable),
    .flush     (flush),
    .frame_len (frame_len),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_cnt (frame_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- FIFO model ----------------
  assign rempty = (rd_idx == wr_idx);
  assign rdata  = mem[rd_idx % MEMD];

  always @(posedge rclk) begin
    if (rinc) begin
      check("rinc_while_empty", 32'(rempty), 32'd0);
      if (!rempty) rd_idx <= rd_idx + 1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge rclk) begin
    if (!rrst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", m_data, m_last);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", 32'({m_last, m_data}), 32'(mon_exp));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [DSIZE-1:0] d, input logic last);
    mem[wr_idx % MEMD] = d;
    wr_idx++;
    exp_q.push_back({last, d});
  endtask

  task automatic discard_all();
    wr_idx = rd_idx;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rrst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; frame_len = '0;
    discard_all();
    step(2);
    rrst = 1'b0;
    step(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_frame_cnt(input string name, input logic [LENW-1:0] v, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_cnt == v) begin hit = 1'b1; break; end
      step(1);
    end
    check(name, 32'(hit), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DSIZE-1:0] d4b [7];
    logic             l4a [7];
    logic             l4b [7];
    logic             rinc_exp [5];
    logic             vld_exp [5];
    int               pulses;

    for (int i = 0; i < MEMD; i++) mem[i] = '0;
    step(2);
    rrst = 1'b0;
    step(1);

    // Reset state
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Three-word stream, one-cycle FIFO-to-output latency
    do_reset();
    push_word(8'h11, 1'b0); push_word(8'h22, 1'b0); push_word(8'h33, 1'b0);
    m_ready = 1'b1; enable = 1'b1;
    @(negedge rclk);
    check("t2_idle_rinc", 32'(rinc), 32'd0);
    rinc_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vld_exp  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      check("t2_rinc", 32'(rinc), 32'(rinc_exp[c]));
      check("t2_m_valid", 32'(m_valid), 32'(vld_exp[c]));
    end
    step(1);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd3);

    // Back-pressure: only two pops, head held
    do_reset();
    push_word(8'h11, 1'b0); push_word(8'h22, 1'b0); push_word(8'h33, 1'b0); push_word(8'h44, 1'b0);
    enable = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge rclk);
      if (rinc) pulses++;
    end
    check("t3_pops", 32'(pulses), 32'd2);
    check("t3_head", 32'(m_data), 32'h11);
    check("t3_busy", 32'(busy), 32'd1);
    step(1);
    m_ready = 1'b1;
    wait_drain("t3_drain", 20);

    // Frames of 3
    do_reset();
    frame_len = 8'd3; m_ready = 1'b1;
    l4a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) push_word(8'(8'h40 + i), l4a[i]);
    enable = 1'b1;
    wait_drain("t4a_drain", 30);
    check("t4a_frame_cnt", 32'(frame_cnt), 32'd1);

    // Length change mid-frame applies from the next frame
    do_reset();
    frame_len = 8'd3; m_ready = 1'b1;
    d4b = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    l4b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) push_word(d4b[i], l4b[i]);
    enable = 1'b1;
    wait_frame_cnt("t4b_reach_beat2", 8'd1, 20);
    frame_len = 8'd2;
    wait_drain("t4b_drain", 30);
    check("t4b_frame_cnt", 32'(frame_cnt), 32'd0);

    // Flush with a full buffer and five words in the FIFO
    do_reset();
    enable = 1'b1;
    push_word(8'h61, 1'b0); push_word(8'h62, 1'b0);
    step(5);
    for (int i = 0; i < 5; i++) push_word(8'(8'h70 + i), 1'b0);
    step(3);
    check("t5_pre_rinc", 32'(rinc), 32'd0);
    check("t5_pre_valid", 32'(m_valid), 32'd1);
    flush = 1'b1; enable = 1'b0;
    exp_q.delete();
    step(1);
    flush = 1'b0;
    check("t5_valid_after_flush", 32'(m_valid), 32'd0);
    check("t5_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
    check("t5_busy_flush", 32'(busy), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (dbg_state == ST_IDLE) break;
      if (rinc) pulses++;
    end
    check("t5_flush_pops", 32'(pulses), 32'd5);
    check("t5_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);

    // Flush and enable together: flush wins, then back to RUN
    step(1);
    flush = 1'b1; enable = 1'b1;
    step(1);
    flush = 1'b0;
    check("fe_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
    step(1);
    check("fe_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    step(1);
    check("fe_state_run", 32'(dbg_state), 32'(ST_RUN));

    // Reset in the middle of a stream
    do_reset();
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'(8'h80 + i), 1'b0);
    wait_drain("t1_drain", 20);
    check("t1_frame_cnt5", 32'(frame_cnt), 32'd5);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(8'(8'h90 + i), 1'b0);
    step(5);
    check("t1_full_valid", 32'(m_valid), 32'd1);
    check("t1_full_rinc", 32'(rinc), 32'd0);
    rrst = 1'b1;
    discard_all();
    step(1);
    check("t1_rst_valid", 32'(m_valid), 32'd0);
    check("t1_rst_rinc", 32'(rinc), 32'd0);
    check("t1_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rrst = 1'b0;
    enable = 1'b0;
    step(1);

    // Length 0 means 256 beats; enable drop mid-frame still drains buffer
    do_reset();
    frame_len = 8'd0; m_ready = 1'b1;
    for (int i = 1; i <= 260; i++) push_word(8'(i), (i == 256));
    enable = 1'b1;
    wait_frame_cnt("t6_reach_100", 8'd100, 400);
    m_ready = 1'b0;
    step(3);
    enable = 1'b0;
    step(2);
    check("t6_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_idle_valid", 32'(m_valid), 32'd1);
    check("t6_idle_rinc", 32'(rinc), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    m_ready = 1'b1;
    step(3);
    check("t6_drained_valid", 32'(m_valid), 32'd0);
    check("t6_drained_cnt", 32'(frame_cnt), 32'd102);
    check("t6_drained_rinc", 32'(rinc), 32'd0);
    enable = 1'b1;
    wait_drain("t6_drain", 400);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
